// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared triangle types and sizes for the dispatch path
package gfx_pkg;
    localparam int VTX_BITS   = 10;
    localparam int TRI_VERTS  = 3;
    localparam int TRI_BITS   = TRI_VERTS * 2 * VTX_BITS;
    localparam int OBUF_DEPTH = 2;

    // Three vertices, each an (x,y) pair of VTX_BITS-wide coordinates.
    typedef logic [TRI_VERTS-1:0][1:0][VTX_BITS-1:0] tri_t;
endpackage

// File: rtl/tri_rr_arbiter.sv
// rtl/tri_rr_arbiter.sv - round-robin grant over producer valids, pointer advances past the winner
module tri_rr_arbiter #(
    parameter int NUM_SRC = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       block,
    input  logic [NUM_SRC-1:0]         valid,
    output logic [NUM_SRC-1:0]         grant,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx
);
    localparam int PTR_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0] rr_ptr;
    logic             hit;
    int               cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        hit       = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_SRC;
            if (!hit && valid[PTR_W'(cand)]) begin
                hit       = 1'b1;
                grant_idx = PTR_W'(cand);
            end
        end
        // The search result is still computed while blocked so fifo_tri_in stays meaningful.
        if (hit && !Reset && !block) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/triangle_dispatch_ctrl.sv
// rtl/triangle_dispatch_ctrl.sv - merges producers into triangle_fifo and streams its output to the rasterizer
module triangle_dispatch_ctrl
    import gfx_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_SRC-1:0] src_valid,
    input  tri_t [NUM_SRC-1:0] src_tri,
    output logic [NUM_SRC-1:0] src_ready,
    output logic               fifo_w_en,
    output tri_t               fifo_tri_in,
    output logic               fifo_r_en,
    input  tri_t               fifo_tri_out,
    input  logic               fifo_is_empty,
    input  logic               fifo_is_full,
    output logic               rast_valid,
    output tri_t               rast_tri,
    input  logic               rast_ready,
    output logic [CNT_W-1:0]   tri_count,
    output logic               idle
);
    logic [NUM_SRC-1:0]         grant;
    logic [$clog2(NUM_SRC)-1:0] grant_idx;

    tri_rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .Clk       (Clk),
        .Reset     (Reset),
        .block     (fifo_is_full),
        .valid     (src_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign src_ready   = grant;
    assign fifo_w_en   = |grant;
    assign fifo_tri_in = src_tri[grant_idx];

    tri_t       obuf [OBUF_DEPTH];
    logic [1:0] count;
    logic       inflight;
    logic       pop;
    logic [2:0] occupancy;
    logic [1:0] keep;

    assign rast_valid = !Reset && (count != 2'd0);
    assign rast_tri   = obuf[0];
    assign pop        = rast_valid && rast_ready;
    // Entries committed to the buffer after this edge, counting the read already in flight.
    assign occupancy  = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign keep       = count - {1'b0, pop};
    assign fifo_r_en  = !Reset && !fifo_is_empty && (occupancy < 3'(OBUF_DEPTH));
    assign idle       = fifo_is_empty && !inflight && (count == 2'd0) && !(|src_valid);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count     <= 2'd0;
            inflight  <= 1'b0;
            tri_count <= '0;
        end else begin
            inflight <= fifo_r_en;
            count    <= occupancy[1:0];
            if (pop) begin
                tri_count <= tri_count + CNT_W'(1);
                obuf[0]   <= obuf[1];
            end
            // RAM data lands behind whatever survives this cycle's pop.
            if (inflight) begin
                if (keep == 2'd0) begin
                    obuf[0] <= fifo_tri_out;
                end else begin
                    obuf[1] <= fifo_tri_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_triangle_dispatch_ctrl.sv
// tb/tb_triangle_dispatch_ctrl.sv - randomized self-checking bench with FIFO model and delivery scoreboard
module tb_triangle_dispatch_ctrl;
    import gfx_pkg::*;

    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 4;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic [NUM_SRC-1:0] src_valid = '0;
    tri_t [NUM_SRC-1:0] src_tri = '0;
    logic [NUM_SRC-1:0] src_ready;
    logic               fifo_w_en;
    tri_t               fifo_tri_in;
    logic               fifo_r_en;
    tri_t               fifo_tri_out = '0;
    logic               fifo_is_empty = 1'b1;
    logic               fifo_is_full = 1'b0;
    logic               rast_valid;
    tri_t               rast_tri;
    logic               rast_ready = 1'b0;
    logic [CNT_W-1:0]   tri_count;
    logic               idle;

    int   n_checks = 0;
    int   n_pass = 0;
    tri_t fifo_q[$];
    tri_t exp_q[$];
    int   fifo_depth = 16;
    int   m_ptr = 0;
    int   m_count = 0;

    triangle_dispatch_ctrl #(
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .src_valid     (src_valid),
        .src_tri       (src_tri),
        .src_ready     (src_ready),
        .fifo_w_en     (fifo_w_en),
        .fifo_tri_in   (fifo_tri_in),
        .fifo_r_en     (fifo_r_en),
        .fifo_tri_out  (fifo_tri_out),
        .fifo_is_empty (fifo_is_empty),
        .fifo_is_full  (fifo_is_full),
        .rast_valid    (rast_valid),
        .rast_tri      (rast_tri),
        .rast_ready    (rast_ready),
        .tri_count     (tri_count),
        .idle          (idle)
    );

    always #5 Clk = ~Clk;

    function automatic tri_t rand_tri();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[TRI_BITS-1:0];
    endfunction

    // Which source a fair round-robin arbiter should take this cycle.
    function automatic logic [NUM_SRC-1:0] model_grant();
        logic [NUM_SRC-1:0] g;
        g = '0;
        if (!Reset && !fifo_is_full) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                int idx;
                idx = (m_ptr + k) % NUM_SRC;
                if (src_valid[idx]) begin
                    g[idx] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    // triangle_fifo model plus the order-of-acceptance scoreboard.
    always @(posedge Clk) begin
        logic [NUM_SRC-1:0] g;
        if (Reset) begin
            fifo_q.delete();
            exp_q.delete();
            m_ptr = 0;
            m_count = 0;
            fifo_is_empty <= 1'b1;
            fifo_is_full  <= 1'b0;
        end else begin
            g = model_grant();
            if (rast_valid && rast_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_count++;
            end
            for (int k = 0; k < NUM_SRC; k++) begin
                if (g[k]) begin
                    exp_q.push_back(src_tri[k]);
                    m_ptr = (k + 1) % NUM_SRC;
                end
            end
            if (fifo_r_en && fifo_q.size() > 0) fifo_tri_out <= fifo_q.pop_front();
            if (fifo_w_en) fifo_q.push_back(fifo_tri_in);
            fifo_is_empty <= (fifo_q.size() == 0);
            fifo_is_full  <= (fifo_q.size() >= fifo_depth);
        end
    end

    task automatic test_reset();
        Reset = 1'b1;
        src_valid = 2'b11;
        src_tri[0] = rand_tri();
        src_tri[1] = rand_tri();
        rast_ready = 1'b1;
        repeat (2) begin
            @(negedge Clk); #1;
            n_checks++; if (src_ready !== 2'b00) $display("FAIL rst_src_ready: got %b want 00", src_ready); else n_pass++;
            n_checks++; if (fifo_w_en !== 1'b0) $display("FAIL rst_w_en: got %b want 0", fifo_w_en); else n_pass++;
            n_checks++; if (fifo_r_en !== 1'b0) $display("FAIL rst_r_en: got %b want 0", fifo_r_en); else n_pass++;
            n_checks++; if (rast_valid !== 1'b0) $display("FAIL rst_rast_valid: got %b want 0", rast_valid); else n_pass++;
        end
        @(negedge Clk);
        Reset = 1'b0;
        src_valid = '0;
        #1;
        n_checks++; if (tri_count !== '0) $display("FAIL rst_tri_count: got %0d want 0", tri_count); else n_pass++;
        n_checks++; if (rast_valid !== 1'b0) $display("FAIL rst_after_valid: got %b want 0", rast_valid); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle); else n_pass++;
    endtask

    task automatic test_single();
        tri_t t0;
        t0 = rand_tri();
        @(negedge Clk);
        src_valid = 2'b01;
        src_tri[0] = t0;
        rast_ready = 1'b1;
        #1;
        n_checks++; if (src_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", src_ready); else n_pass++;
        n_checks++; if (fifo_w_en !== 1'b1 || fifo_tri_in !== t0) $display("FAIL single_write: got en=%b %h want en=1 %h", fifo_w_en, fifo_tri_in, t0); else n_pass++;
        @(negedge Clk);
        src_valid = '0;
        #1;
        n_checks++; if (fifo_r_en !== 1'b1) $display("FAIL single_r_en: got %b want 1", fifo_r_en); else n_pass++;
        @(negedge Clk); #1;
        n_checks++; if (rast_valid !== 1'b0) $display("FAIL single_latency: got valid=%b want 0", rast_valid); else n_pass++;
        @(negedge Clk); #1;
        n_checks++; if (rast_valid !== 1'b1 || rast_tri !== t0) $display("FAIL single_out: got valid=%b %h want valid=1 %h", rast_valid, rast_tri, t0); else n_pass++;
        @(negedge Clk); #1;
        n_checks++; if (tri_count !== CNT_W'(1)) $display("FAIL single_count: got %0d want 1", tri_count); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL single_idle: got %b want 1", idle); else n_pass++;
    endtask

    task automatic test_fairness();
        logic [NUM_SRC-1:0] eg;
        logic [NUM_SRC-1:0] prev_eg;
        int cnt0 = 0;
        int cnt1 = 0;
        int del = 0;
        rast_ready = 1'b1;
        prev_eg = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            src_valid = (i < 8) ? 2'b11 : 2'b00;
            src_tri[0] = rand_tri();
            src_tri[1] = rand_tri();
            #1;
            eg = model_grant();
            n_checks++; if (src_ready !== eg) $display("FAIL fair_grant: got %b want %b", src_ready, eg); else n_pass++;
            if (i > 0 && i < 8) begin
                n_checks++; if (src_ready !== ~prev_eg) $display("FAIL fair_alternate: got %b want %b", src_ready, ~prev_eg); else n_pass++;
            end
            prev_eg = eg;
            cnt0 += int'(src_ready[0]);
            cnt1 += int'(src_ready[1]);
            if (rast_valid && rast_ready) begin
                n_checks++;
                if (exp_q.size() == 0 || rast_tri !== exp_q[0]) $display("FAIL fair_order: got %h want %h", rast_tri, (exp_q.size() > 0) ? exp_q[0] : 'x);
                else n_pass++;
                del++;
            end
        end
        n_checks++; if (cnt0 !== 4 || cnt1 !== 4) $display("FAIL fair_split: got %0d/%0d want 4/4", cnt0, cnt1); else n_pass++;
        n_checks++; if (del !== 8) $display("FAIL fair_delivered: got %0d want 8", del); else n_pass++;
    endtask

    task automatic test_backpressure();
        tri_t written[10];
        int   acc = 0;
        int   cyc = 0;
        for (int i = 0; i < 10; i++) written[i] = rand_tri();
        rast_ready = 1'b0;
        while (acc < 10 && cyc < 40) begin
            @(negedge Clk);
            src_valid = 2'b01;
            src_tri[0] = written[acc];
            #1;
            n_checks++; if (src_ready !== model_grant()) $display("FAIL bp_grant: got %b want %b", src_ready, model_grant()); else n_pass++;
            if (rast_valid) begin
                n_checks++; if (rast_tri !== written[0]) $display("FAIL bp_hold: got %h want %h", rast_tri, written[0]); else n_pass++;
            end
            if (src_ready[0]) acc++;
            cyc++;
        end
        n_checks++; if (acc !== 10) $display("FAIL bp_accept: got %0d want 10", acc); else n_pass++;
        @(negedge Clk);
        src_valid = '0;
        repeat (2) @(negedge Clk);
        #1;
        n_checks++; if (rast_valid !== 1'b1 || rast_tri !== written[0]) $display("FAIL bp_stall: got valid=%b %h want valid=1 %h", rast_valid, rast_tri, written[0]); else n_pass++;
        n_checks++; if (fifo_r_en !== 1'b0) $display("FAIL bp_r_en: got %b want 0", fifo_r_en); else n_pass++;
        rast_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge Clk); #1;
            end
            n_checks++;
            if (rast_valid !== 1'b1 || rast_tri !== written[i]) $display("FAIL bp_drain[%0d]: got valid=%b %h want valid=1 %h", i, rast_valid, rast_tri, written[i]);
            else n_pass++;
        end
        @(negedge Clk); #1;
        n_checks++; if (rast_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", rast_valid); else n_pass++;
        n_checks++; if (tri_count !== CNT_W'(m_count)) $display("FAIL bp_count: got %0d want %0d", tri_count, CNT_W'(m_count)); else n_pass++;
    endtask

    task automatic test_full();
        tri_t acc_t[7];
        int   acc = 0;
        int   del = 0;
        int   last = -1;
        fifo_depth = 4;
        src_tri[0] = rand_tri();
        src_tri[1] = rand_tri();
        for (int cyc = 0; cyc < 60 && del < 7; cyc++) begin
            @(negedge Clk);
            if (last >= 0) src_tri[last] = rand_tri();
            src_valid = (acc < 7) ? 2'b11 : 2'b00;
            rast_ready = (cyc >= 20);
            #1;
            n_checks++; if (src_ready !== model_grant()) $display("FAIL full_grant: got %b want %b", src_ready, model_grant()); else n_pass++;
            if (fifo_is_full) begin
                n_checks++; if (src_ready !== 2'b00 || fifo_w_en !== 1'b0) $display("FAIL full_blocked: got ready=%b w_en=%b want 00/0", src_ready, fifo_w_en); else n_pass++;
            end
            if (cyc == 19) begin
                n_checks++; if (acc !== 6 || fifo_is_full !== 1'b1) $display("FAIL full_capacity: got acc=%0d full=%b want 6/1", acc, fifo_is_full); else n_pass++;
            end
            if (rast_valid && rast_ready) begin
                n_checks++;
                if (del >= acc || rast_tri !== acc_t[del]) $display("FAIL full_order[%0d]: got %h", del, rast_tri);
                else n_pass++;
                del++;
            end
            last = -1;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (src_ready[s] && acc < 7) begin
                    acc_t[acc] = src_tri[s];
                    acc++;
                    last = s;
                end
            end
        end
        n_checks++; if (del !== 7) $display("FAIL full_delivered: got %0d want 7", del); else n_pass++;
        src_valid = '0;
        fifo_depth = 16;
    endtask

    task automatic test_reset_mid();
        rast_ready = 1'b0;
        src_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            src_tri[0] = rand_tri();
        end
        #1;
        n_checks++; if (rast_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b want 1", rast_valid); else n_pass++;
        @(negedge Clk);
        Reset = 1'b1;
        src_valid = '0;
        rast_ready = 1'b1;
        #1;
        n_checks++; if (rast_valid !== 1'b0 || fifo_r_en !== 1'b0) $display("FAIL rmid_during: got valid=%b r_en=%b want 0/0", rast_valid, fifo_r_en); else n_pass++;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        n_checks++; if (rast_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", rast_valid); else n_pass++;
        n_checks++; if (tri_count !== '0) $display("FAIL rmid_count: got %0d want 0", tri_count); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rmid_idle: got %b want 1", idle); else n_pass++;
        repeat (3) begin
            @(negedge Clk); #1;
            n_checks++; if (rast_valid !== 1'b0) $display("FAIL rmid_no_partial: got %b want 0", rast_valid); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        tri_t sent[17];
        int   acc = 0;
        int   del = 0;
        rast_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && del < 17; cyc++) begin
            @(negedge Clk);
            src_valid = (acc < 17) ? 2'b10 : 2'b00;
            src_tri[1] = rand_tri();
            #1;
            if (rast_valid && rast_ready) begin
                n_checks++;
                if (del >= acc || rast_tri !== sent[del]) $display("FAIL wrap_order[%0d]: got %h", del, rast_tri);
                else n_pass++;
                del++;
            end
            if (src_ready[1] && acc < 17) begin
                sent[acc] = src_tri[1];
                acc++;
            end
        end
        src_valid = '0;
        @(negedge Clk); #1;
        n_checks++; if (tri_count !== CNT_W'(17)) $display("FAIL wrap_count: got %0d want %0d", tri_count, CNT_W'(17)); else n_pass++;
    endtask

    task automatic test_random();
        logic exp_idle;
        fifo_depth = 3;
        for (int cyc = 0; cyc < 430; cyc++) begin
            @(negedge Clk);
            src_valid = (cyc < 400) ? NUM_SRC'($urandom_range(0, 3)) : '0;
            src_tri[0] = rand_tri();
            src_tri[1] = rand_tri();
            rast_ready = (cyc >= 400) || ($urandom_range(0, 3) != 0);
            #1;
            n_checks++; if (src_ready !== model_grant()) $display("FAIL rnd_grant: got %b want %b", src_ready, model_grant()); else n_pass++;
            if (fifo_is_full) begin
                n_checks++; if (fifo_w_en !== 1'b0) $display("FAIL rnd_w_full: got %b want 0", fifo_w_en); else n_pass++;
            end
            if (fifo_is_empty) begin
                n_checks++; if (fifo_r_en !== 1'b0) $display("FAIL rnd_r_empty: got %b want 0", fifo_r_en); else n_pass++;
            end
            if (rast_valid && rast_ready) begin
                n_checks++;
                if (exp_q.size() == 0 || rast_tri !== exp_q[0]) $display("FAIL rnd_order: got %h want %h", rast_tri, (exp_q.size() > 0) ? exp_q[0] : 'x);
                else n_pass++;
            end
            n_checks++; if (tri_count !== CNT_W'(m_count)) $display("FAIL rnd_count: got %0d want %0d", tri_count, CNT_W'(m_count)); else n_pass++;
            exp_idle = (exp_q.size() == 0) && (src_valid == '0);
            n_checks++; if (idle !== exp_idle) $display("FAIL rnd_idle: got %b want %b", idle, exp_idle); else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_drained: got %0d pending want 0", exp_q.size()); else n_pass++;
        fifo_depth = 16;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_full();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/triangle_dispatch_ctrl.md
Name: triangle_dispatch_ctrl

Overview:
- Controller between triangle producers (transform/clip units) and the rasterizer, owning both sides of one triangle_fifo instance.
- Write side: round-robin arbiter merging NUM_SRC valid/ready producer streams into the FIFO write port.
- Read side: sequences FIFO reads, absorbs the 1-cycle on-chip RAM read latency in a 2-entry output buffer, and presents a valid/ready stream to the rasterizer.

Parameters:
- NUM_SRC, 2, number of producer ports (2..4).
- CNT_W, 16, width of the dispatched-triangle counter.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- src_valid  in  NUM_SRC  producer i has a triangle.
- src_tri  in  NUM_SRC x tri_t  producer triangles.
- src_ready  out  NUM_SRC  producer i accepted this cycle (one-hot or zero).
- fifo_w_en  out  1  FIFO write enable.
- fifo_tri_in  out  tri_t  FIFO write data.
- fifo_r_en  out  1  FIFO read enable.
- fifo_tri_out  in  tri_t  FIFO read data, valid the cycle after fifo_r_en.
- fifo_is_empty  in  1  FIFO empty flag.
- fifo_is_full  in  1  FIFO full flag.
- rast_valid  out  1  triangle available to rasterizer.
- rast_tri  out  tri_t  triangle to rasterizer.
- rast_ready  in  1  rasterizer accepts.
- tri_count  out  CNT_W  triangles delivered since reset; wraps.
- idle  out  1  no triangle anywhere in the block or FIFO and no src_valid.

Behaviour:
- tri_t = [2:0][1:0][9:0]: 3 vertices of (x,y), 10 bits each, 60 bits total.
- Reset (synchronous, active-high):
  - rr_ptr=0, buffer count=0, inflight=0, tri_count=0.
  - All *_ready, *_en and rast_valid outputs are 0 during and after the reset cycle.
  - The same Reset clears the FIFO.
  - Reset mid-operation discards any in-flight and buffered triangles with no partial output.

Write arbitration (combinational grant, registered pointer):
- If fifo_is_full=1 or Reset=1: grant=0.
- Otherwise grant the first valid source searching from rr_ptr upward, wrapping at NUM_SRC.
- src_ready=grant; fifo_w_en=|grant; fifo_tri_in=src_tri[granted].
- On a grant to source k: rr_ptr <= (k+1 == NUM_SRC) ? 0 : k+1. With no grant, rr_ptr holds.
- fifo_w_en is never asserted while fifo_is_full=1.
- One triangle accepted per cycle maximum.

Read sequencing:
- Output buffer holds 2 entries (count 0..2). inflight is 1 the cycle after fifo_r_en.
- fifo_r_en = !Reset && !fifo_is_empty && (count + inflight - pop) < 2, where pop = rast_valid && rast_ready.
- fifo_r_en is never asserted while fifo_is_empty=1.
- When inflight=1, fifo_tri_out is captured into the buffer tail in that cycle.
- rast_valid = (count>0); rast_tri = buffer head.
- A push and a pop in the same cycle leave count unchanged; order is preserved.
- Steady state: one triangle per cycle when rast_ready is held high and the FIFO is non-empty.
- FIFO latency: minimum 2 cycles from fifo_r_en to rast_valid on an empty buffer (r_en at cycle t, data captured at t+1, rast_valid at t+1 registered → visible t+2).
- rast_tri holds stable while rast_valid=1 && rast_ready=0.
- tri_count increments on each pop, wrapping at 2^CNT_W.
- A simultaneous FIFO write and read in the same cycle is legal; the controller drives both ports independently.
- idle = fifo_is_empty && !inflight && count==0 && !(|src_valid).

Decomposition:
- Package gfx_pkg: typedef tri_t (logic [2:0][1:0][9:0]), VTX_BITS=10, TRI_VERTS=3.
- One sub-module: tri_rr_arbiter (NUM_SRC parameter; valid in, grant out, rr pointer inside).
- The output buffer stays inline.

Test Plan:
- Single source: src_valid[0]=1 with T0, FIFO empty, rast_ready=1 → src_ready[0]=1 in cycle 0; fifo_r_en next cycle; rast_valid with T0 two cycles later; tri_count=1.
- Fairness: both sources continuously valid for 8 cycles → grants alternate 0,1,0,1…; 4 accepted from each; rast_tri sequence matches the interleaving.
- Backpressure: rast_ready=0, 10 triangles written → buffer fills to 2, fifo_r_en stops, rast_tri stays on the first triangle; release rast_ready → 10 delivered in order on consecutive cycles.
- Full: FIFO size 4, rast_ready=0, 7 offered → src_ready stays 0 once fifo_is_full=1; no fifo_w_en while full; no loss after draining.
- Reset mid-stream: Reset asserted with count=2 and inflight=1 → next cycle rast_valid=0, tri_count=0, idle=1 (src_valid=0).
- Counter wrap: CNT_W=4, deliver 17 triangles → tri_count=1.
